ad_cache_reader: RTL
====================

Name: ad_cache_reader

Overview:
- Drains the read side of the ADC ping-pong cache.
- On each one-cycle bank-switch pulse, it issues exactly FRAME_LEN read strobes into the cache and absorbs the RAM read latency.
- It presents the samples as a framed valid/ready stream with start/end markers for the downstream packetiser.
- It runs entirely in the cache read-clock domain.

Parameters:
- DATA_NBIT, 16, sample width (equals `AD_DATA_NBIT).
- FRAME_LEN, 1024, samples per cache half (equals `AD_CHE_DATA_SIZE); must be ≥2.
- RD_LAT, 2, cycles from sampled rd to valid rdata.
- FIFO_DEPTH, 4, output skid FIFO entries; must be ≥ RD_LAT+1.

Ports:
- clk  in  1  read clock; same clock as the cache rclk.
- rst  in  1  synchronous, active-high reset.
- switch  in  1  one-cycle pulse from cache: new half-frame ready, cache raddr cleared this cycle.
- rd  out  1  read strobe to cache; advances cache raddr.
- rdata  in  DATA_NBIT  cache read data.
- out_data  out  DATA_NBIT  stream sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when valid&ready.
- out_sof  out  1  qualifies first sample of frame (valid with out_valid).
- out_eof  out  1  qualifies last sample of frame.
- busy  out  1  frame in progress (READ or DRAIN).
- overrun  out  1  one-cycle pulse: switch arrived while busy.
- overrun_cnt  out  16  saturating count of overruns.

Behaviour:
- Reset: rd=0, out_valid=0, out_sof=0, out_eof=0, busy=0, overrun=0, overrun_cnt=0. FIFO and in-flight tracking cleared; state=IDLE.
- Reset wins over every other event, including a switch in the same cycle.
- States:
  - IDLE: on switch, go to READ. Load req_cnt=FRAME_LEN and emit_cnt=FRAME_LEN.
  - READ: rd is asserted only when inflight + fifo_count < FIFO_DEPTH and req_cnt > 0. Each rd decrements req_cnt. When req_cnt reaches 0, go to DRAIN.
  - DRAIN: stay until the last sample (emit_cnt==1) is accepted with valid&ready, then return to IDLE.
- rd is never asserted in the same cycle as switch. The first rd occurs no earlier than the cycle after switch, which is when cache raddr=0.
- Latency: the word addressed by rd sampled high at cycle t is captured from rdata at cycle t+RD_LAT into the FIFO. Track this with an RD_LAT-deep valid shift register; inflight is the count of ones in it.
- FIFO never overflows by construction. An overflow is an assertion failure in verification.
- Stream:
  - out_valid = FIFO not empty. out_data = FIFO head.
  - Holding rule: out_data, out_sof and out_eof stay stable while out_valid & !out_ready.
  - out_sof is high on the first sample of the frame (emit_cnt==FRAME_LEN).
  - out_eof is high on the last sample (emit_cnt==1).
  - emit_cnt decrements on each accepted sample.
- A capture and a pop in the same cycle are both honoured; fifo_count is unchanged.
- Throughput: with out_ready held high, one sample per cycle after the initial RD_LAT fill. Frame latency from switch to first out_valid is RD_LAT+2 cycles.
- busy=1 in READ and DRAIN.
- Overrun (switch while busy):
  - overrun pulses for 1 cycle; overrun_cnt increments, saturating at 0xFFFF.
  - FIFO and in-flight captures are flushed, so no data from the old frame appears after this cycle.
  - The new frame restarts as from IDLE: sof on its first sample, no eof ever emitted for the truncated frame.
- switch while IDLE is a normal start, with no overrun.

Test Plan:
- Nominal: rst, then switch with out_ready=1, FRAME_LEN=8, cache model returns addr+0x100 → 8 rd pulses, out_data 0x100..0x107 on consecutive cycles. sof on 0x100, eof on 0x107, busy falls the cycle after the eof accept.
- Backpressure: out_ready pattern 1,0,0,1 repeating → no sample lost or duplicated. out_data stable while stalled. rd throttled so inflight+fifo_count never exceeds 4.
- Overrun: second switch after 3 accepted samples → overrun=1 for one cycle, overrun_cnt=1. No eof emitted for the aborted frame. Next output is sof with 0x100.
- Back-to-back: switch arrives 2 cycles after eof accept → no overrun, second frame is complete and correct.
- Reset mid-frame: rst after 5 samples → all outputs at reset values the next cycle. A following switch yields a clean full frame.
- Saturation: force 65536 overruns → overrun_cnt stays 0xFFFF.

Source files
------------

// File: rtl/ad_cache_reader.sv
// ---------------------------------------------------------------------------
// ad_cache_reader
//
// Drains the read side of the ADC ping-pong cache. Each one-cycle bank-switch
// pulse starts a frame: exactly FRAME_LEN read strobes go to the cache, the
// RAM read latency is absorbed by an RD_LAT-deep valid pipe, and the samples
// leave through a small skid FIFO as a framed valid/ready stream.
// Runs entirely in the cache read-clock domain.
//
// Ports
//   clk          read clock (same as cache rclk)
//   rst          synchronous, active-high reset
//   switch       one-cycle pulse: new half-frame ready, cache raddr cleared
//   rd           read strobe to cache, advances cache raddr
//   rdata        cache read data, valid RD_LAT cycles after a sampled rd
//   out_data     stream sample (FIFO head)
//   out_valid    out_data valid
//   out_ready    downstream ready
//   out_sof      first sample of a frame, qualified by out_valid
//   out_eof      last sample of a frame, qualified by out_valid
//   busy         frame in progress (READ or DRAIN)
//   overrun      one-cycle pulse: switch arrived while busy
//   overrun_cnt  saturating overrun count
//   dbg_state    current FSM state (0 IDLE, 1 READ, 2 DRAIN)
//
// Handshake: a sample transfers on every rising clk edge where
// out_valid & out_ready. While out_valid is high and out_ready is low,
// out_data, out_sof and out_eof hold their values; out_valid never drops
// without a transfer except on reset or overrun flush.
// ---------------------------------------------------------------------------
module ad_cache_reader #(
    parameter int DATA_NBIT  = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 switch,
    output logic                 rd,
    input  logic [DATA_NBIT-1:0] rdata,
    output logic [DATA_NBIT-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 busy,
    output logic                 overrun,
    output logic [15:0]          overrun_cnt,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_req_cnt;
    logic [CNT_W-1:0]     r_emit_cnt;
    logic [RD_LAT-1:0]    r_vsr;        // bit i set: a read issued i+1 cycles ago
    logic [DATA_NBIT-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [FCNT_W-1:0]    r_fcnt;
    logic                 r_overrun;
    logic [15:0]          r_ovr_cnt;

    logic [OCC_W-1:0]     w_inflight;
    logic [OCC_W-1:0]     w_occ;
    logic                 w_rd;
    logic                 w_capture;
    logic                 w_pop;
    logic                 w_valid;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + OCC_W'(r_vsr[i]);
        end
    end

    // Every read already issued will land in the FIFO, so in-flight reads
    // count against FIFO space; this is what makes overflow impossible.
    assign w_occ     = w_inflight + OCC_W'(r_fcnt);
    assign w_valid   = (r_fcnt != '0);
    assign w_pop     = w_valid && out_ready;
    assign w_capture = r_vsr[RD_LAT-1];

    // No read in a switch cycle: the cache clears raddr then, and an
    // overrun flush must not leave a stale read in flight.
    assign w_rd = !rst && !switch && (r_state == S_READ) &&
                  (r_req_cnt != '0) && (w_occ < OCC_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req_cnt  <= '0;
            r_emit_cnt <= '0;
            r_vsr      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fcnt     <= '0;
            r_overrun  <= 1'b0;
            r_ovr_cnt  <= '0;
        end else begin
            r_overrun <= 1'b0;
            if (switch) begin
                // A switch always (re)starts a frame; when busy, everything
                // belonging to the old frame is discarded here.
                if (r_state != S_IDLE) begin
                    r_overrun <= 1'b1;
                    if (r_ovr_cnt != 16'hFFFF) begin
                        r_ovr_cnt <= r_ovr_cnt + 16'd1;
                    end
                end
                r_state    <= S_READ;
                r_req_cnt  <= CNT_W'(FRAME_LEN);
                r_emit_cnt <= CNT_W'(FRAME_LEN);
                r_vsr      <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_fcnt     <= '0;
            end else begin
                r_vsr <= (r_vsr << 1) | RD_LAT'(w_rd);

                if (w_capture) begin
                    r_wptr <= next_ptr(r_wptr);
                end
                if (w_pop) begin
                    r_rptr     <= next_ptr(r_rptr);
                    r_emit_cnt <= r_emit_cnt - CNT_W'(1);
                end
                if (w_capture && !w_pop) begin
                    r_fcnt <= r_fcnt + FCNT_W'(1);
                end else if (!w_capture && w_pop) begin
                    r_fcnt <= r_fcnt - FCNT_W'(1);
                end

                case (r_state)
                    S_READ: begin
                        if (w_rd) begin
                            r_req_cnt <= r_req_cnt - CNT_W'(1);
                            if (r_req_cnt == CNT_W'(1)) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (w_pop && (r_emit_cnt == CNT_W'(1))) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wptr] <= rdata;
        end
    end

    assign rd          = w_rd;
    assign out_valid   = w_valid;
    assign out_data    = r_mem[r_rptr];
    assign out_sof     = w_valid && (r_emit_cnt == CNT_W'(FRAME_LEN));
    assign out_eof     = w_valid && (r_emit_cnt == CNT_W'(1));
    assign busy        = (r_state != S_IDLE);
    assign overrun     = r_overrun;
    assign overrun_cnt = r_ovr_cnt;
    assign dbg_state   = r_state;

endmodule
